// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: PC-1/PC-2 permutations, shift schedule,
// FSM state encoding and the round-key beat payload.
package des_pkg;

  localparam int unsigned KEY_W  = 64;
  localparam int unsigned CD_W   = 56;
  localparam int unsigned HALF_W = 28;
  localparam int unsigned RK_W   = 48;
  localparam int unsigned RND_W  = 4;
  localparam int unsigned STG_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ks_state_e;

  typedef struct packed {
    logic [RK_W-1:0]  rk;
    logic [RND_W-1:0] round;
    logic [STG_W-1:0] stage;
    logic             stage_dec;
    logic             last;
  } rk_beat_t;

  // Encrypt-direction left-rotate amount before round r (r = 1..16).
  localparam logic [1:0] SHIFT_SCHED [1:16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Source bit (1 = MSB of the 64-bit key) for each PC-1 output bit, MSB first.
  localparam logic [6:0] PC1_TAB [56] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  // Source bit (1 = MSB of the 56-bit CD) for each PC-2 output bit, MSB first.
  localparam logic [5:0] PC2_TAB [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] o;
    o = '0;
    for (int i = 0; i < int'(CD_W); i++) begin
      o[int'(CD_W) - 1 - i] = k[int'(KEY_W) - int'(PC1_TAB[i])];
    end
    return o;
  endfunction

  function automatic logic [RK_W-1:0] pc2(input logic [CD_W-1:0] cd);
    logic [RK_W-1:0] o;
    o = '0;
    for (int i = 0; i < int'(RK_W); i++) begin
      o[int'(RK_W) - 1 - i] = cd[int'(CD_W) - int'(PC2_TAB[i])];
    end
    return o;
  endfunction

  // DES keys carry odd parity per byte; flag any byte with even parity.
  function automatic logic key_parity_bad(input logic [KEY_W-1:0] k);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(KEY_W / 8); i++) begin
      bad = bad | ~(^k[8*i +: 8]);
    end
    return bad;
  endfunction

endpackage

// File: rtl/des_ks_core.sv
// Combinational CD update: first-round load from PC-1 or per-round rotation,
// plus PC-2 of the resulting CD.
module des_ks_core
  import des_pkg::*;
(
  input  logic [KEY_W-1:0] key_sel,
  input  logic             load_first,
  input  logic             dir_dec,
  input  logic             rot_two,
  input  logic [CD_W-1:0]  cd_cur,
  output logic [CD_W-1:0]  cd_nxt_c,
  output logic [RK_W-1:0]  rk_nxt_c
);

  logic [CD_W-1:0] cd_pc1;

  function automatic logic [HALF_W-1:0] rot_half(input logic [HALF_W-1:0] h,
                                                 input logic right,
                                                 input logic two);
    logic [HALF_W-1:0] r;
    case ({right, two})
      2'b00:   r = {h[HALF_W-2:0], h[HALF_W-1]};
      2'b01:   r = {h[HALF_W-3:0], h[HALF_W-1:HALF_W-2]};
      2'b10:   r = {h[0], h[HALF_W-1:1]};
      default: r = {h[1:0], h[HALF_W-1:2]};
    endcase
    return r;
  endfunction

  // Decrypt starts from the fully rotated (= unrotated) CD; encrypt from rotl1.
  always_comb begin
    cd_pc1 = pc1(key_sel);
    if (load_first) begin
      if (dir_dec) begin
        cd_nxt_c = cd_pc1;
      end else begin
        cd_nxt_c = {rot_half(cd_pc1[CD_W-1:HALF_W], 1'b0, 1'b0),
                    rot_half(cd_pc1[HALF_W-1:0], 1'b0, 1'b0)};
      end
    end else begin
      cd_nxt_c = {rot_half(cd_cur[CD_W-1:HALF_W], dir_dec, rot_two),
                  rot_half(cd_cur[HALF_W-1:0], dir_dec, rot_two)};
    end
    rk_nxt_c = pc2(cd_nxt_c);
  end

endmodule

// File: rtl/des_key_sched_seq.sv
// Sequential DES/3DES round-key streamer: accepts 1 or 3 keys per load and emits
// 16*NUM_KEYS registered round keys over a valid/ready interface.
module des_key_sched_seq
  import des_pkg::*;
#(
  parameter int unsigned NUM_KEYS     = 1,
  parameter bit          PARITY_CHECK = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      key_valid,
  output logic                      key_ready,
  input  logic [KEY_W*NUM_KEYS-1:0] key_in,
  input  logic                      decrypt,
  input  logic                      abort,
  output logic                      rk_valid,
  input  logic                      rk_ready,
  output logic [RK_W-1:0]           rk,
  output logic [RND_W-1:0]          rk_round,
  output logic [STG_W-1:0]          rk_stage,
  output logic                      rk_stage_dec,
  output logic                      rk_last,
  output logic                      key_parity_err
);

  localparam int unsigned KEYS_W = KEY_W * NUM_KEYS;

  if (NUM_KEYS != 1 && NUM_KEYS != 3) begin : g_bad_num_keys
    $error("des_key_sched_seq: NUM_KEYS must be 1 or 3");
  end

  ks_state_e         state_q, state_d;
  logic [KEYS_W-1:0] key_q, key_d;
  logic              dec_q, dec_d;
  logic [CD_W-1:0]   cd_q, cd_d;
  rk_beat_t          beat_q, beat_d;
  logic              key_ready_q, key_ready_d;
  logic              rk_valid_q, rk_valid_d;
  logic              perr_q, perr_d;

  logic [KEYS_W-1:0] key_src;
  logic [KEY_W-1:0]  key_sel;
  logic              ld_dec;
  logic [STG_W-1:0]  sel_stage;
  logic [STG_W-1:0]  stage_nx;
  logic              load_first;
  logic              core_dec;
  logic              rot_two;
  logic [4:0]        r_idx;
  logic [CD_W-1:0]   cd_nxt_c;
  logic [RK_W-1:0]   rk_nxt_c;
  logic              perr_c;

  // Core operand select: load from key_in in IDLE, next stage's key at round 15, else rotate.
  always_comb begin
    key_src    = key_q;
    ld_dec     = dec_q;
    sel_stage  = '0;
    stage_nx   = beat_q.stage + STG_W'(1);
    load_first = 1'b1;
    core_dec   = 1'b0;
    rot_two    = 1'b0;
    r_idx      = 5'd1;
    key_sel    = '0;
    if (state_q == IDLE) begin
      key_src  = key_in;
      ld_dec   = decrypt;
      core_dec = decrypt;
    end else if (beat_q.round == RND_W'(15)) begin
      sel_stage = stage_nx;
      core_dec  = dec_q ^ stage_nx[0];
    end else begin
      load_first = 1'b0;
      core_dec   = beat_q.stage_dec;
      r_idx      = beat_q.stage_dec ? (5'd16 - 5'(beat_q.round)) : (5'(beat_q.round) + 5'd2);
      rot_two    = (SHIFT_SCHED[r_idx] == 2'd2);
    end
    // Key 1 lives in the top slice; decrypt order walks keys from the bottom slice.
    for (int k = 0; k < int'(NUM_KEYS); k++) begin
      if (ld_dec ? (k == int'(sel_stage)) : (k == int'(NUM_KEYS) - 1 - int'(sel_stage))) begin
        key_sel = key_src[KEY_W*k +: KEY_W];
      end
    end
  end

  always_comb begin
    perr_c = 1'b0;
    for (int k = 0; k < int'(NUM_KEYS); k++) begin
      perr_c = perr_c | key_parity_bad(key_in[KEY_W*k +: KEY_W]);
    end
  end

  des_ks_core u_core (
    .key_sel    (key_sel),
    .load_first (load_first),
    .dir_dec    (core_dec),
    .rot_two    (rot_two),
    .cd_cur     (cd_q),
    .cd_nxt_c   (cd_nxt_c),
    .rk_nxt_c   (rk_nxt_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    dec_d       = dec_q;
    cd_d        = cd_q;
    beat_d      = beat_q;
    key_ready_d = key_ready_q;
    rk_valid_d  = rk_valid_q;
    perr_d      = perr_q;
    if (abort) begin
      state_d          = IDLE;
      key_ready_d      = 1'b1;
      rk_valid_d       = 1'b0;
      beat_d.round     = '0;
      beat_d.stage     = '0;
      beat_d.stage_dec = 1'b0;
      beat_d.last      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_valid) begin
            state_d          = RUN;
            key_d            = key_in;
            dec_d            = decrypt;
            cd_d             = cd_nxt_c;
            perr_d           = PARITY_CHECK ? perr_c : 1'b0;
            key_ready_d      = 1'b0;
            rk_valid_d       = 1'b1;
            beat_d.rk        = rk_nxt_c;
            beat_d.round     = '0;
            beat_d.stage     = '0;
            beat_d.stage_dec = decrypt;
            beat_d.last      = 1'b0;
          end
        end
        RUN: begin
          if (rk_ready) begin
            if (beat_q.last) begin
              state_d          = IDLE;
              key_ready_d      = 1'b1;
              rk_valid_d       = 1'b0;
              beat_d.round     = '0;
              beat_d.stage     = '0;
              beat_d.stage_dec = 1'b0;
              beat_d.last      = 1'b0;
            end else begin
              cd_d      = cd_nxt_c;
              beat_d.rk = rk_nxt_c;
              if (beat_q.round == RND_W'(15)) begin
                beat_d.round     = '0;
                beat_d.stage     = stage_nx;
                beat_d.stage_dec = dec_q ^ stage_nx[0];
              end else begin
                beat_d.round = beat_q.round + RND_W'(1);
              end
              beat_d.last = (beat_d.round == RND_W'(15)) &&
                            (beat_d.stage == STG_W'(NUM_KEYS - 1));
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      key_q       <= '0;
      dec_q       <= 1'b0;
      cd_q        <= '0;
      beat_q      <= '0;
      key_ready_q <= 1'b1;
      rk_valid_q  <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      dec_q       <= dec_d;
      cd_q        <= cd_d;
      beat_q      <= beat_d;
      key_ready_q <= key_ready_d;
      rk_valid_q  <= rk_valid_d;
      perr_q      <= perr_d;
    end
  end

  assign key_ready      = key_ready_q;
  assign rk_valid       = rk_valid_q;
  assign rk             = beat_q.rk;
  assign rk_round       = beat_q.round;
  assign rk_stage       = beat_q.stage;
  assign rk_stage_dec   = beat_q.stage_dec;
  assign rk_last        = beat_q.last;
  assign key_parity_err = perr_q;

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Scoreboard bench for des_key_sched_seq: one single-DES and one 3DES instance,
// driven with the classic 133457799BBCDFF1 key schedule and weak/zero keys.
module tb_des_key_sched_seq;

  typedef struct packed {
    logic [47:0] rk;
    logic [3:0]  round;
    logic [1:0]  stage;
    logic        sdec;
    logic        last;
  } exp_t;

  localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_WK = 64'h0101010101010101;
  localparam logic [63:0] KEY_Z  = 64'h0000000000000000;

  // Encrypt-order subkeys K1..K16 of KEY_A.
  logic [47:0] ks_tab [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rk_ready;
  logic rand_on, ready_force;

  logic         a_key_valid, a_key_ready, a_decrypt, a_abort, a_rk_valid;
  logic [63:0]  a_key_in;
  logic [47:0]  a_rk;
  logic [3:0]   a_round;
  logic [1:0]   a_stage;
  logic         a_sdec, a_last, a_perr;

  logic         b_key_valid, b_key_ready, b_decrypt, b_abort, b_rk_valid;
  logic [191:0] b_key_in;
  logic [47:0]  b_rk;
  logic [3:0]   b_round;
  logic [1:0]   b_stage;
  logic         b_sdec, b_last, b_perr;

  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb, ga, gb;

  des_key_sched_seq #(.NUM_KEYS(1), .PARITY_CHECK(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .key_valid(a_key_valid), .key_ready(a_key_ready),
    .key_in(a_key_in), .decrypt(a_decrypt), .abort(a_abort), .rk_valid(a_rk_valid),
    .rk_ready(rk_ready), .rk(a_rk), .rk_round(a_round), .rk_stage(a_stage),
    .rk_stage_dec(a_sdec), .rk_last(a_last), .key_parity_err(a_perr)
  );

  des_key_sched_seq #(.NUM_KEYS(3), .PARITY_CHECK(1'b1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .key_valid(b_key_valid), .key_ready(b_key_ready),
    .key_in(b_key_in), .decrypt(b_decrypt), .abort(b_abort), .rk_valid(b_rk_valid),
    .rk_ready(rk_ready), .rk(b_rk), .rk_round(b_round), .rk_stage(b_stage),
    .rk_stage_dec(b_sdec), .rk_last(b_last), .key_parity_err(b_perr)
  );

  // Consumer ready: random or forced, updated shortly after each rising edge.
  initial begin
    rk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      rk_ready = rand_on ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Monitor: pop and compare on every accepted beat, away from the rising edge.
  always @(negedge clk) begin
    if (a_rk_valid) begin
      checks++;
      if (a_key_ready !== 1'b0) begin
        errors++;
        $display("FAIL a_key_ready_in_run got=%0b need=0", a_key_ready);
      end
    end
    if (a_rk_valid && rk_ready) begin
      checks++;
      ga = {a_rk, a_round, a_stage, a_sdec, a_last};
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_beat got=%h", ga);
      end else begin
        ea = qa.pop_front();
        if (ga !== ea) begin
          errors++;
          $display("FAIL a_beat got=%h need=%h (rk,round,stage,sdec,last)", ga, ea);
        end
      end
    end
    if (b_rk_valid && rk_ready) begin
      checks++;
      gb = {b_rk, b_round, b_stage, b_sdec, b_last};
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_beat got=%h", gb);
      end else begin
        eb = qb.pop_front();
        if (gb !== eb) begin
          errors++;
          $display("FAIL b_beat got=%h need=%h (rk,round,stage,sdec,last)", gb, eb);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s got=%0h need=%0h", name, got, need);
    end
  endtask

  // Push expected beats for one stage. zero: all-zero subkeys; rev: K16..K1 order.
  task automatic push_stage(input bit inst, input bit zero, input bit rev, input logic [1:0] stg,
                            input bit sdec, input bit last_stage, input int n);
    exp_t e;
    for (int r = 0; r < n; r++) begin
      e.rk    = zero ? 48'h0 : (rev ? ks_tab[15 - r] : ks_tab[r]);
      e.round = 4'(r);
      e.stage = stg;
      e.sdec  = sdec;
      e.last  = last_stage && (r == 15);
      if (inst) qb.push_back(e);
      else      qa.push_back(e);
    end
  endtask

  // Called and returns at posedge+1.
  task automatic load(input bit inst, input logic [191:0] k, input bit dec);
    int n = 0;
    while (((inst ? b_key_ready : a_key_ready) !== 1'b1) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) begin
      errors++;
      $display("FAIL load_timeout inst=%0d got=not_ready need=ready", inst);
    end
    if (inst) begin b_key_in = k; b_decrypt = dec; b_key_valid = 1'b1; end
    else begin a_key_in = k[63:0]; a_decrypt = dec; a_key_valid = 1'b1; end
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the latched copy must be used.
    a_key_valid = 1'b0; b_key_valid = 1'b0;
    a_key_in = ~a_key_in; b_key_in = ~b_key_in;
    a_decrypt = ~a_decrypt; b_decrypt = ~b_decrypt;
  endtask

  task automatic wait_done(input bit inst, input int budget);
    int n = 0;
    while ((((inst ? qb.size() : qa.size()) != 0) ||
            ((inst ? b_key_ready : a_key_ready) !== 1'b1)) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL done_timeout inst=%0d got=%0d_left need=0", inst, inst ? qb.size() : qa.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout need=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rand_on = 1'b0; ready_force = 1'b1;
    a_key_valid = 0; a_key_in = '0; a_decrypt = 0; a_abort = 0;
    b_key_valid = 0; b_key_in = '0; b_decrypt = 0; b_abort = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_key_ready", 64'(a_key_ready), 64'd1);
    chk("reset_rk_valid", 64'(a_rk_valid), 64'd0);
    chk("reset_rk", 64'(a_rk), 64'd0);
    chk("reset_rk_fields", 64'({a_round, a_stage, a_sdec, a_last, a_perr}), 64'd0);
    chk("reset_b_key_ready", 64'(b_key_ready), 64'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single DES encrypt with full ready: latency and return-to-idle timing.
    push_stage(0, 0, 0, 2'd0, 0, 1, 16);
    load(0, 192'(KEY_A), 0);
    @(negedge clk);
    chk("lat_rk_valid", 64'(a_rk_valid), 64'd1);
    chk("lat_key_ready", 64'(a_key_ready), 64'd0);
    chk("parity_good", 64'(a_perr), 64'd0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("last_beat_key_ready", 64'(a_key_ready), 64'd0);
    chk("last_beat_flag", 64'(a_last), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bubble_key_ready", 64'(a_key_ready), 64'd1);
    chk("bubble_rk_valid", 64'(a_rk_valid), 64'd0);
    @(posedge clk); #1;
    wait_done(0, 50);

    // Single DES decrypt: reversed schedule, stage direction set.
    push_stage(0, 0, 1, 2'd0, 1, 1, 16);
    load(0, 192'(KEY_A), 1);
    wait_done(0, 50);

    // Parity: all-zero key flags; weak key is clean and yields zero subkeys.
    push_stage(0, 1, 0, 2'd0, 0, 1, 16);
    load(0, 192'(KEY_Z), 0);
    @(negedge clk);
    chk("parity_zero_key", 64'(a_perr), 64'd1);
    @(posedge clk); #1;
    wait_done(0, 50);
    push_stage(0, 1, 0, 2'd0, 0, 1, 16);
    load(0, 192'(KEY_WK), 0);
    @(negedge clk);
    chk("parity_weak_key", 64'(a_perr), 64'd0);
    @(posedge clk); #1;
    wait_done(0, 50);

    // Random backpressure plus ignored key_valid while running.
    rand_on = 1'b1;
    push_stage(0, 0, 0, 2'd0, 0, 1, 16);
    load(0, 192'(KEY_A), 0);
    a_key_valid = 1'b1; a_key_in = KEY_Z; a_decrypt = 1'b1;
    repeat (5) @(posedge clk);
    #1 a_key_valid = 1'b0;
    wait_done(0, 400);
    push_stage(0, 0, 1, 2'd0, 1, 1, 16);
    load(0, 192'(KEY_A), 1);
    wait_done(0, 400);
    rand_on = 1'b0;

    // Abort while round 7 is presented, then a clean restart.
    push_stage(0, 0, 0, 2'd0, 0, 0, 7);
    load(0, 192'(KEY_A), 0);
    repeat (7) @(posedge clk);
    #1 ready_force = 1'b0; a_abort = 1'b1;
    @(posedge clk); #1 a_abort = 1'b0; ready_force = 1'b1;
    @(negedge clk);
    chk("abort_rk_valid", 64'(a_rk_valid), 64'd0);
    chk("abort_key_ready", 64'(a_key_ready), 64'd1);
    chk("abort_counters", 64'({a_round, a_stage}), 64'd0);
    @(posedge clk); #1;
    push_stage(0, 0, 0, 2'd0, 0, 1, 16);
    load(0, 192'(KEY_A), 0);
    wait_done(0, 50);

    // Async reset while round 7 is presented, then decrypt run.
    push_stage(0, 0, 0, 2'd0, 0, 0, 7);
    load(0, 192'(KEY_A), 0);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0; ready_force = 1'b0;
    #2;
    chk("rst_rk_valid", 64'(a_rk_valid), 64'd0);
    chk("rst_key_ready", 64'(a_key_ready), 64'd1);
    chk("rst_rk", 64'(a_rk), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1; ready_force = 1'b1;
    @(posedge clk); #1;
    push_stage(0, 0, 1, 2'd0, 1, 1, 16);
    load(0, 192'(KEY_A), 1);
    wait_done(0, 50);

    // 3DES encrypt with identical keys: E, D, E.
    push_stage(1, 0, 0, 2'd0, 0, 0, 16);
    push_stage(1, 0, 1, 2'd1, 1, 0, 16);
    push_stage(1, 0, 0, 2'd2, 0, 1, 16);
    load(1, {KEY_A, KEY_A, KEY_A}, 0);
    wait_done(1, 100);

    // 3DES encrypt, distinct keys: K3 is the only non-weak one.
    push_stage(1, 1, 0, 2'd0, 0, 0, 16);
    push_stage(1, 1, 0, 2'd1, 1, 0, 16);
    push_stage(1, 0, 0, 2'd2, 0, 1, 16);
    load(1, {KEY_WK, KEY_Z, KEY_A}, 0);
    @(negedge clk);
    chk("b_parity_err", 64'(b_perr), 64'd1);
    @(posedge clk); #1;
    wait_done(1, 100);

    // 3DES decrypt with backpressure: D(K3), E(K2), D(K1) with K1 non-weak.
    rand_on = 1'b1;
    push_stage(1, 1, 0, 2'd0, 1, 0, 16);
    push_stage(1, 1, 0, 2'd1, 0, 0, 16);
    push_stage(1, 0, 1, 2'd2, 1, 1, 16);
    load(1, {KEY_A, KEY_WK, KEY_Z}, 1);
    wait_done(1, 600);
    rand_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
